// File: rtl/fast_pkg.sv
// Shared definitions for the FAST corner scoring block.
//   RING_SIZE       : number of pixels on the Bresenham ring around the centre
//   ARC_LEN_DEFAULT : default minimum contiguous arc length
//   score_width()   : score width able to hold 16 full-scale magnitudes
package fast_pkg;

   localparam int unsigned RING_SIZE       = 16;
   localparam int unsigned ARC_LEN_DEFAULT = 9;

   // Magnitudes are PIXEL_WIDTH+2 bits; summing 16 of them needs 4 more bits.
   function automatic int unsigned score_width(input int unsigned pixel_width);
      return pixel_width + 6;
   endfunction

endpackage

// File: rtl/fast_arc_detect.sv
// Combinational circular arc detector.
//   mask_i : one bit per ring pixel (bit 15 is adjacent to bit 0)
//   hit_o  : 1 when at least ARC_LEN contiguous set bits exist, wrapping around
module fast_arc_detect
   import fast_pkg::*;
#(
   parameter int unsigned ARC_LEN = ARC_LEN_DEFAULT
) (
   input  logic [RING_SIZE-1:0] mask_i,
   output logic                 hit_o
);

   logic [RING_SIZE-1:0] arc;
   logic [3:0]           idx;

   // arc[s] is set when the ARC_LEN pixels starting at s are all set.
   // The 4-bit index wraps modulo the ring size on its own.
   always_comb begin
      arc = '1;
      idx = '0;
      for (int unsigned s = 0; s < RING_SIZE; s++) begin
         for (int unsigned k = 0; k < ARC_LEN; k++) begin
            idx    = 4'(s + k);
            arc[s] = arc[s] & mask_i[idx];
         end
      end
      hit_o = |arc;
   end

endmodule

// File: rtl/fast_corner_score.sv
// FAST corner decision and score, 4-stage pipeline, one candidate per ce cycle.
//   clk, rst        : clock, synchronous active-high reset (dominates ce)
//   ce              : clock enable for every register, valid pipe included
//   in_valid        : candidate valid, aligned with the masks and magnitudes
//   bright, dark    : per ring pixel brighter / darker than the threshold band
//   o0b..o15b       : bright magnitudes per ring pixel (unsigned)
//   o0d..o15d       : dark magnitudes per ring pixel (unsigned)
//   out_valid       : in_valid delayed by 4 enabled cycles
//   is_corner       : bright or dark arc found
//   corner_polarity : 1 = bright arc chosen, 0 = dark arc chosen
//   score           : sum of gated magnitudes of the chosen polarity, 0 when no corner
module fast_corner_score
   import fast_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned ARC_LEN     = ARC_LEN_DEFAULT,
   parameter int unsigned SCORE_W     = score_width(PIXEL_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   in_valid,
   input  logic [15:0]            bright,
   input  logic [15:0]            dark,
   input  logic [PIXEL_WIDTH+1:0] o0b,  o1b,  o2b,  o3b,  o4b,  o5b,  o6b,  o7b,
   input  logic [PIXEL_WIDTH+1:0] o8b,  o9b,  o10b, o11b, o12b, o13b, o14b, o15b,
   input  logic [PIXEL_WIDTH+1:0] o0d,  o1d,  o2d,  o3d,  o4d,  o5d,  o6d,  o7d,
   input  logic [PIXEL_WIDTH+1:0] o8d,  o9d,  o10d, o11d, o12d, o13d, o14d, o15d,
   output logic                   out_valid,
   output logic                   is_corner,
   output logic                   corner_polarity,
   output logic [SCORE_W-1:0]     score
);

   localparam int unsigned MW = PIXEL_WIDTH + 2;

   logic [MW-1:0] raw_b [RING_SIZE];
   logic [MW-1:0] raw_d [RING_SIZE];
   logic [MW-1:0] gb    [RING_SIZE];
   logic [MW-1:0] gd    [RING_SIZE];

   logic [MW:0]   s1b_d [8];
   logic [MW:0]   s1d_d [8];
   logic [MW:0]   s1b_q [8];
   logic [MW:0]   s1d_q [8];
   logic [MW+1:0] s2b_d [4];
   logic [MW+1:0] s2d_d [4];
   logic [MW+1:0] s2b_q [4];
   logic [MW+1:0] s2d_q [4];
   logic [MW+2:0] s3b_d [2];
   logic [MW+2:0] s3d_d [2];
   logic [MW+2:0] s3b_q [2];
   logic [MW+2:0] s3d_q [2];

   logic          hit_b, hit_d;
   logic          hb1_q, hd1_q, hb2_q, hd2_q, hb3_q, hd3_q;
   logic [2:0]    vld_q;

   logic [SCORE_W-1:0] sum_b, sum_d, score_d, score_q;
   logic               corner_d, corner_q, pol_d, pol_q, valid_q;

   assign raw_b = '{o0b, o1b, o2b, o3b, o4b, o5b, o6b, o7b,
                    o8b, o9b, o10b, o11b, o12b, o13b, o14b, o15b};
   assign raw_d = '{o0d, o1d, o2d, o3d, o4d, o5d, o6d, o7d,
                    o8d, o9d, o10d, o11d, o12d, o13d, o14d, o15d};

   fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_b (.mask_i(bright), .hit_o(hit_b));
   fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_d (.mask_i(dark),   .hit_o(hit_d));

   // Magnitudes only count where the matching mask bit is set.
   for (genvar i = 0; i < RING_SIZE; i++) begin : g_gate
      assign gb[i] = bright[i] ? raw_b[i] : '0;
      assign gd[i] = dark[i]   ? raw_d[i] : '0;
   end

   // Adder tree: every level widens by one bit, so no level can overflow.
   for (genvar j = 0; j < 8; j++) begin : g_lvl1
      assign s1b_d[j] = {1'b0, gb[2*j]} + {1'b0, gb[2*j+1]};
      assign s1d_d[j] = {1'b0, gd[2*j]} + {1'b0, gd[2*j+1]};
   end
   for (genvar j = 0; j < 4; j++) begin : g_lvl2
      assign s2b_d[j] = {1'b0, s1b_q[2*j]} + {1'b0, s1b_q[2*j+1]};
      assign s2d_d[j] = {1'b0, s1d_q[2*j]} + {1'b0, s1d_q[2*j+1]};
   end
   for (genvar j = 0; j < 2; j++) begin : g_lvl3
      assign s3b_d[j] = {1'b0, s2b_q[2*j]} + {1'b0, s2b_q[2*j+1]};
      assign s3d_d[j] = {1'b0, s2d_q[2*j]} + {1'b0, s2d_q[2*j+1]};
   end

   // Final selection: bright wins ties when both arcs hit.
   always_comb begin
      sum_b    = SCORE_W'(s3b_q[0]) + SCORE_W'(s3b_q[1]);
      sum_d    = SCORE_W'(s3d_q[0]) + SCORE_W'(s3d_q[1]);
      corner_d = hb3_q | hd3_q;
      pol_d    = 1'b0;
      score_d  = '0;
      if (hb3_q && hd3_q) begin
         pol_d   = (sum_b >= sum_d);
         score_d = pol_d ? sum_b : sum_d;
      end else if (hb3_q) begin
         pol_d   = 1'b1;
         score_d = sum_b;
      end else if (hd3_q) begin
         score_d = sum_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned j = 0; j < 8; j++) begin
            s1b_q[j] <= '0;
            s1d_q[j] <= '0;
         end
         for (int unsigned j = 0; j < 4; j++) begin
            s2b_q[j] <= '0;
            s2d_q[j] <= '0;
         end
         for (int unsigned j = 0; j < 2; j++) begin
            s3b_q[j] <= '0;
            s3d_q[j] <= '0;
         end
         {hb1_q, hd1_q, hb2_q, hd2_q, hb3_q, hd3_q} <= '0;
         vld_q    <= '0;
         valid_q  <= 1'b0;
         corner_q <= 1'b0;
         pol_q    <= 1'b0;
         score_q  <= '0;
      end else if (ce) begin
         s1b_q    <= s1b_d;
         s1d_q    <= s1d_d;
         s2b_q    <= s2b_d;
         s2d_q    <= s2d_d;
         s3b_q    <= s3b_d;
         s3d_q    <= s3d_d;
         hb1_q    <= hit_b;
         hd1_q    <= hit_d;
         hb2_q    <= hb1_q;
         hd2_q    <= hd1_q;
         hb3_q    <= hb2_q;
         hd3_q    <= hd2_q;
         vld_q    <= {vld_q[1:0], in_valid};
         valid_q  <= vld_q[2];
         corner_q <= corner_d;
         pol_q    <= pol_d;
         score_q  <= score_d;
      end
   end

   assign out_valid       = valid_q;
   assign is_corner       = corner_q;
   assign corner_polarity = pol_q;
   assign score           = score_q;

endmodule

// File: tb/tb_fast_corner_score.sv
module tb_fast_corner_score;

   logic        clk = 1'b0;
   logic        rst, ce, in_valid;
   logic [15:0] bright, dark;
   logic [9:0]  ob [16];
   logic [9:0]  od [16];

   logic        ov9, ic9, cp9, ov1, ic1, cp1;
   logic [13:0] sc9, sc1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   typedef struct {
      int unsigned due;
      logic [15:0] e9;
      logic [15:0] e1;
   } exp_t;

   always #5 clk = ~clk;

   fast_corner_score #(.PIXEL_WIDTH(8), .ARC_LEN(9)) dut9 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .bright(bright), .dark(dark),
      .o0b(ob[0]), .o1b(ob[1]), .o2b(ob[2]), .o3b(ob[3]), .o4b(ob[4]), .o5b(ob[5]),
      .o6b(ob[6]), .o7b(ob[7]), .o8b(ob[8]), .o9b(ob[9]), .o10b(ob[10]), .o11b(ob[11]),
      .o12b(ob[12]), .o13b(ob[13]), .o14b(ob[14]), .o15b(ob[15]),
      .o0d(od[0]), .o1d(od[1]), .o2d(od[2]), .o3d(od[3]), .o4d(od[4]), .o5d(od[5]),
      .o6d(od[6]), .o7d(od[7]), .o8d(od[8]), .o9d(od[9]), .o10d(od[10]), .o11d(od[11]),
      .o12d(od[12]), .o13d(od[13]), .o14d(od[14]), .o15d(od[15]),
      .out_valid(ov9), .is_corner(ic9), .corner_polarity(cp9), .score(sc9));

   fast_corner_score #(.PIXEL_WIDTH(8), .ARC_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .bright(bright), .dark(dark),
      .o0b(ob[0]), .o1b(ob[1]), .o2b(ob[2]), .o3b(ob[3]), .o4b(ob[4]), .o5b(ob[5]),
      .o6b(ob[6]), .o7b(ob[7]), .o8b(ob[8]), .o9b(ob[9]), .o10b(ob[10]), .o11b(ob[11]),
      .o12b(ob[12]), .o13b(ob[13]), .o14b(ob[14]), .o15b(ob[15]),
      .o0d(od[0]), .o1d(od[1]), .o2d(od[2]), .o3d(od[3]), .o4d(od[4]), .o5d(od[5]),
      .o6d(od[6]), .o7d(od[7]), .o8d(od[8]), .o9d(od[9]), .o10d(od[10]), .o11d(od[11]),
      .o12d(od[12]), .o13d(od[13]), .o14d(od[14]), .o15d(od[15]),
      .out_valid(ov1), .is_corner(ic1), .corner_polarity(cp1), .score(sc1));

   // ---------------- reference model ----------------
   function automatic int unsigned longest_run(input logic [15:0] m);
      int unsigned best = 0;
      int unsigned run  = 0;
      if (m == 16'hFFFF) return 16;
      for (int i = 0; i < 32; i++) begin
         if (m[i % 16]) run++;
         else run = 0;
         if (run > best) best = run;
      end
      return best;
   endfunction

   // Returns {is_corner, polarity, score[13:0]} for the current inputs.
   function automatic logic [15:0] model(input int unsigned arc_len);
      int unsigned sb = 0;
      int unsigned sd = 0;
      int unsigned sc;
      bit hb, hd, pol;
      for (int i = 0; i < 16; i++) begin
         if (bright[i]) sb += ob[i];
         if (dark[i])   sd += od[i];
      end
      hb = longest_run(bright) >= arc_len;
      hd = longest_run(dark)   >= arc_len;
      if (hb && hd) begin
         pol = (sb >= sd);
         sc  = pol ? sb : sd;
      end else if (hb) begin
         pol = 1'b1; sc = sb;
      end else if (hd) begin
         pol = 1'b0; sc = sd;
      end else begin
         pol = 1'b0; sc = 0;
      end
      return {hb | hd, pol, 14'(sc)};
   endfunction

   function automatic logic [15:0] rand_mask();
      int unsigned len = $urandom_range(16, 0);
      int unsigned rot = $urandom_range(15, 0);
      logic [31:0] base;
      logic [15:0] m;
      base = (32'h1 << len) - 32'h1;
      m    = base[15:0];
      m    = (m << rot) | (m >> (16 - rot));
      if ($urandom_range(3, 0) == 0) m = m | (16'($urandom) & 16'($urandom));
      if ($urandom_range(3, 0) == 0) m = m & ~(16'h1 << $urandom_range(15, 0));
      return m;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic step(input logic ce_v);
      ce = ce_v;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bright = '0;
      dark   = '0;
      for (int i = 0; i < 16; i++) begin
         ob[i] = '0;
         od[i] = '0;
      end
   endtask

   // Present one candidate and advance 3 enabled edges; one more edge shows the result.
   task automatic push_one();
      in_valid = 1'b1;
      step(1'b1);
      in_valid = 1'b0;
      step(1'b1);
      step(1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0;
      clear_inputs();
      step(1'b0);
      step(1'b1);
      n_checks++;
      if ({ov9, ic9, cp9, sc9} !== 17'd0) $display("FAIL reset9: got %b_%b_%b_%0d want all 0", ov9, ic9, cp9, sc9);
      else n_pass++;
      n_checks++;
      if ({ov1, ic1, cp1, sc1} !== 17'd0) $display("FAIL reset1: got %b_%b_%b_%0d want all 0", ov1, ic1, cp1, sc1);
      else n_pass++;
      rst = 1'b0;
      step(1'b1);
   endtask

   task automatic test_wrap_arc();
      clear_inputs();
      bright = 16'hF01F;
      for (int i = 0; i < 16; i++) ob[i] = 10'd5;
      push_one();
      n_checks++;
      if (ov9 !== 1'b0) $display("FAIL wrap_latency: out_valid %b after 3 cycles, want 0", ov9);
      else n_pass++;
      step(1'b1);
      n_checks++;
      if ({ov9, ic9, cp9, sc9} !== {1'b1, 1'b1, 1'b1, 14'd45}) $display("FAIL wrap9: got %b_%b_%b_%0d want 1_1_1_45", ov9, ic9, cp9, sc9);
      else n_pass++;
      n_checks++;
      if ({ov1, ic1, cp1, sc1} !== {1'b1, 1'b1, 1'b1, 14'd45}) $display("FAIL wrap1: got %b_%b_%b_%0d want 1_1_1_45", ov1, ic1, cp1, sc1);
      else n_pass++;
   endtask

   task automatic test_short_arc();
      clear_inputs();
      dark = 16'h00FF;
      for (int i = 0; i < 16; i++) od[i] = 10'd20;
      push_one();
      step(1'b1);
      n_checks++;
      if ({ov9, ic9, cp9, sc9} !== {1'b1, 1'b0, 1'b0, 14'd0}) $display("FAIL short9: got %b_%b_%b_%0d want 1_0_0_0", ov9, ic9, cp9, sc9);
      else n_pass++;
      n_checks++;
      if ({ov1, ic1, cp1, sc1} !== {1'b1, 1'b1, 1'b0, 14'd160}) $display("FAIL short1: got %b_%b_%b_%0d want 1_1_0_160", ov1, ic1, cp1, sc1);
      else n_pass++;
   endtask

   task automatic test_gating();
      logic [15:0] m;
      clear_inputs();
      m = 16'h01FF;
      bright = m;
      for (int i = 0; i < 16; i++) ob[i] = m[i] ? 10'd3 : 10'd100;
      for (int i = 0; i < 16; i++) od[i] = 10'd999;
      push_one();
      step(1'b1);
      n_checks++;
      if ({ov9, ic9, cp9, sc9} !== {1'b1, 1'b1, 1'b1, 14'd27}) $display("FAIL gate9: got %b_%b_%b_%0d want 1_1_1_27", ov9, ic9, cp9, sc9);
      else n_pass++;
      n_checks++;
      if ({ov1, ic1, cp1, sc1} !== {1'b1, 1'b1, 1'b1, 14'd27}) $display("FAIL gate1: got %b_%b_%b_%0d want 1_1_1_27", ov1, ic1, cp1, sc1);
      else n_pass++;
   endtask

   task automatic test_both_polarities();
      clear_inputs();
      bright = 16'h0001; ob[0] = 10'd7;
      dark   = 16'h0002; od[1] = 10'd7;
      push_one();
      step(1'b1);
      n_checks++;
      if ({ov1, ic1, cp1, sc1} !== {1'b1, 1'b1, 1'b1, 14'd7}) $display("FAIL tie1: got %b_%b_%b_%0d want 1_1_1_7", ov1, ic1, cp1, sc1);
      else n_pass++;
      n_checks++;
      if ({ov9, ic9, cp9, sc9} !== {1'b1, 1'b0, 1'b0, 14'd0}) $display("FAIL tie9: got %b_%b_%b_%0d want 1_0_0_0", ov9, ic9, cp9, sc9);
      else n_pass++;
      od[1] = 10'd8;
      push_one();
      step(1'b1);
      n_checks++;
      if ({ov1, ic1, cp1, sc1} !== {1'b1, 1'b1, 1'b0, 14'd8}) $display("FAIL dark_wins1: got %b_%b_%b_%0d want 1_1_0_8", ov1, ic1, cp1, sc1);
      else n_pass++;
   endtask

   task automatic test_max_magnitude();
      bright = 16'hFFFF;
      dark   = 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
         ob[i] = 10'd1023;
         od[i] = 10'd1023;
      end
      push_one();
      step(1'b1);
      n_checks++;
      if ({ov9, ic9, cp9, sc9} !== {1'b1, 1'b1, 1'b1, 14'd16368}) $display("FAIL max9: got %b_%b_%b_%0d want 1_1_1_16368", ov9, ic9, cp9, sc9);
      else n_pass++;
      n_checks++;
      if ({ov1, ic1, cp1, sc1} !== {1'b1, 1'b1, 1'b1, 14'd16368}) $display("FAIL max1: got %b_%b_%b_%0d want 1_1_1_16368", ov1, ic1, cp1, sc1);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      for (int k = 0; k < 3; k++) begin
         bright = 16'hFFFF; dark = rand_mask();
         for (int i = 0; i < 16; i++) begin
            ob[i] = 10'($urandom);
            od[i] = 10'($urandom);
         end
         in_valid = 1'b1;
         step(1'b1);
      end
      rst = 1'b1;
      step(1'b0);
      rst = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if ({ov9, ic9, cp9, sc9} !== 17'd0) $display("FAIL midrst9: got %b_%b_%b_%0d want all 0", ov9, ic9, cp9, sc9);
      else n_pass++;
      n_checks++;
      if ({ov1, ic1, cp1, sc1} !== 17'd0) $display("FAIL midrst1: got %b_%b_%b_%0d want all 0", ov1, ic1, cp1, sc1);
      else n_pass++;
      for (int k = 0; k < 6; k++) begin
         step(1'b1);
         n_checks++;
         if ({ov9, ov1} !== 2'b00) $display("FAIL stale_valid: cycle %0d got %b%b want 00", k, ov9, ov1);
         else n_pass++;
      end
   endtask

   // Streams candidates under a ce pattern and checks order, latency and hold against a scoreboard.
   task automatic test_stream(input int unsigned n_cand, input bit fixed_pattern);
      exp_t        q[$];
      exp_t        item;
      int unsigned sent   = 0;
      int unsigned en_cnt = 0;
      int unsigned cyc    = 0;
      logic        cev, ev;
      logic [15:0] e9, e1;
      logic [16:0] obs9, obs1, prev9, prev1;
      prev9 = {ov9, ic9, cp9, sc9};
      prev1 = {ov1, ic1, cp1, sc1};
      while ((sent < n_cand || q.size() != 0) && cyc < 4000) begin
         cev = fixed_pattern ? (cyc % 3 == 0) : ($urandom_range(4, 0) != 0);
         bright = rand_mask();
         dark   = rand_mask();
         for (int i = 0; i < 16; i++) begin
            ob[i] = 10'($urandom);
            od[i] = 10'($urandom);
         end
         in_valid = (sent < n_cand) && (fixed_pattern || ($urandom_range(3, 0) != 0));
         e9 = model(9);
         e1 = model(1);
         step(cev);
         if (cev) begin
            en_cnt++;
            while (q.size() != 0 && q[0].due < en_cnt) void'(q.pop_front());
            if (in_valid) begin
               item.due = en_cnt + 3;
               item.e9  = e9;
               item.e1  = e1;
               q.push_back(item);
               sent++;
            end
         end
         obs9 = {ov9, ic9, cp9, sc9};
         obs1 = {ov1, ic1, cp1, sc1};
         if (!cev) begin
            n_checks++;
            if (obs9 !== prev9) $display("FAIL hold9: cyc %0d got %h want %h", cyc, obs9, prev9);
            else n_pass++;
            n_checks++;
            if (obs1 !== prev1) $display("FAIL hold1: cyc %0d got %h want %h", cyc, obs1, prev1);
            else n_pass++;
         end else begin
            ev = (q.size() != 0) && (q[0].due == en_cnt);
            if (ev) begin
               n_checks++;
               if (obs9 !== {1'b1, q[0].e9}) $display("FAIL result9: cyc %0d got %h want %h", cyc, obs9, {1'b1, q[0].e9});
               else n_pass++;
               n_checks++;
               if (obs1 !== {1'b1, q[0].e1}) $display("FAIL result1: cyc %0d got %h want %h", cyc, obs1, {1'b1, q[0].e1});
               else n_pass++;
            end else begin
               n_checks++;
               if ({ov9, ov1} !== 2'b00) $display("FAIL spurious_valid: cyc %0d got %b%b want 00", cyc, ov9, ov1);
               else n_pass++;
            end
         end
         prev9 = obs9;
         prev1 = obs1;
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (sent != n_cand || q.size() != 0) $display("FAIL stream_budget: sent %0d pending %0d want %0d sent 0 pending", sent, q.size(), n_cand);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; in_valid = 1'b0;
      clear_inputs();
      test_reset();
      test_wrap_arc();
      test_short_arc();
      test_gating();
      test_both_polarities();
      test_stream(6, 1'b1);
      test_reset_midstream();
      test_max_magnitude();
      test_stream(300, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
